// File: rtl/fmt_dec_ascii.sv
`default_nettype none
// ============================================================================
// Module   : fmt_dec_ascii
// Purpose  : Sequential decimal formatter. Accepts one binary word per
//            handshake, converts it with a double-dabble pass, then streams
//            its right-justified %d-style ASCII field one character per beat.
// Ports    : clk, rst_n            clock / async active-low reset
//            in_valid/in_ready     input word handshake
//            in_data, in_signed    value and two's-complement flag
//            out_valid/out_ready   character handshake
//            out_char, out_last    ASCII character, final-character marker
//            busy                  high while converting or emitting
// Options  : FMT_DEC_ZERO_PAD_EN   when defined, leading pad positions emit
//                                  '0' and the sign slot is fixed at position 0
// Revision : 1.0 - initial release
// ============================================================================
module fmt_dec_ascii #(
    parameter int WIDTH = 32,
    parameter int NDIG  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last,
    output logic             busy
);

    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(NDIG + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;

    localparam logic [7:0] C_SPACE = 8'h20;
    localparam logic [7:0] C_MINUS = 8'h2D;
    localparam logic [7:0] C_ZERO  = 8'h30;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_mag;
    logic [BW-1:0]    r_bcd;
    logic [BW-1:0]    w_bcd_next;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic             r_sgn;
    logic             r_neg;

    logic             w_accept;
    logic             w_beat;
    logic             w_in_neg;
    logic             w_idx_last;
    logic [7:0]       w_char;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_beat     = (r_state == S_EMIT) && out_ready;
    assign w_in_neg   = in_signed && in_data[WIDTH-1];
    // Signed fields carry one extra leading slot for the sign.
    assign w_idx_last = (r_idx == (r_sgn ? IW'(NDIG) : IW'(NDIG - 1)));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CONV;
            S_CONV:  if (r_cnt == CW'(WIDTH - 1)) w_next = S_EMIT;
            S_EMIT:  if (w_beat && w_idx_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_EMIT);
        out_last  = (r_state == S_EMIT) && w_idx_last;
        out_char  = (r_state == S_EMIT) ? w_char : C_SPACE;
    end

    // ---------------- datapath ----------------
    // The WIDTH-bit two's-complement negate equals the low bits of a
    // WIDTH+1-bit negate; for -2**(WIDTH-1) it yields 2**(WIDTH-1), which is
    // exactly the magnitude when read as unsigned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_idx <= '0;
            r_sgn <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mag <= w_in_neg ? (~in_data + 1'b1) : in_data;
                        r_bcd <= '0;
                        r_cnt <= '0;
                        r_idx <= '0;
                        r_sgn <= in_signed;
                        r_neg <= w_in_neg;
                    end
                end
                S_CONV: begin
                    r_bcd <= w_bcd_next;
                    r_mag <= r_mag << 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_EMIT: begin
                    if (w_beat) r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Double-dabble step: correct every nibble >= 5, then shift in the next
    // magnitude bit (MSB first).
    always_comb begin
        logic [BW-1:0] v_adj;
        v_adj = r_bcd;
        for (int j = 0; j < NDIG; j++) begin
            if (v_adj[4*j +: 4] >= 4'd5) v_adj[4*j +: 4] = v_adj[4*j +: 4] + 4'd3;
        end
        w_bcd_next = (v_adj << 1) | BW'(r_mag[WIDTH-1]);
    end

    // ---------------- character selection ----------------
    // Digit position d counts from the most significant BCD digit (d=0);
    // in a signed field position 0 is the extra slot, so d = idx - 1.
    always_comb begin
        int       v_d;
        logic [3:0] v_dig;
`ifndef FMT_DEC_ZERO_PAD_EN
        int       v_k;
`endif
        v_d   = int'(r_idx) - (r_sgn ? 1 : 0);
        v_dig = 4'd0;
        for (int j = 0; j < NDIG; j++) begin
            if (j == v_d) v_dig = r_bcd[4*(NDIG-1-j) +: 4];
        end
`ifdef FMT_DEC_ZERO_PAD_EN
        if (r_sgn && (r_idx == '0)) w_char = r_neg ? C_MINUS : C_SPACE;
        else                        w_char = C_ZERO + {4'h0, v_dig};
`else
        // k: most significant nonzero digit; the last digit for a zero value.
        v_k = NDIG - 1;
        for (int j = NDIG - 1; j >= 0; j--) begin
            if (r_bcd[4*(NDIG-1-j) +: 4] != 4'd0) v_k = j;
        end
        if (v_d >= v_k)                     w_char = C_ZERO + {4'h0, v_dig};
        else if (r_sgn && (v_d == v_k - 1)) w_char = r_neg ? C_MINUS : C_SPACE;
        else                                w_char = C_SPACE;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_fmt_dec_ascii.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmt_dec_ascii
// Purpose  : Scoreboard bench for fmt_dec_ascii; expected text is produced by
//            $sformatf-based field rendering and compared character by
//            character by an independent output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmt_dec_ascii;

    localparam int WIDTH = 32;
    localparam int NDIG  = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_signed = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_char;
    logic             out_last;
    logic             busy;

    fmt_dec_ascii #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_char(out_char), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    byte exp_q[$];
    bit  last_q[$];
    int  cyc = 0;
    int  acc_cyc = 0;
    bit  wait_first = 0;
    bit  chk_busy = 0;
    int  field_beat = 0;
    int  ready_mode = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference field rendering from the %d rules.
    function automatic void push_exp(logic [WIDTH-1:0] d, logic s);
        string  str;
        longint v;
        bit     neg;
        int     L;
        L   = s ? NDIG + 1 : NDIG;
        neg = s && d[WIDTH-1];
        v   = neg ? ((longint'(1) << WIDTH) - longint'(d)) : longint'(d);
        str = $sformatf("%0d", v);
`ifdef FMT_DEC_ZERO_PAD_EN
        while (str.len() < NDIG) str = {"0", str};
        if (s) begin
            if (neg) str = {"-", str};
            else     str = {" ", str};
        end
`else
        if (neg) str = {"-", str};
        while (str.len() < L) str = {" ", str};
`endif
        for (int i = 0; i < str.len(); i++) begin
            exp_q.push_back(str[i]);
            last_q.push_back(i == str.len() - 1);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom % 2);
            default: out_ready = 1'b0;
        endcase
    end

    // Output monitor / scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            wait_first = 0;
            chk_busy   = 0;
            field_beat = 0;
        end else begin
            if (chk_busy) begin
                chk("in_ready_drop", 64'(in_ready), 64'd0);
                chk("busy_after_accept", 64'(busy), 64'd1);
                chk_busy = 0;
            end
            if (in_valid && in_ready) begin
                acc_cyc    = cyc;
                wait_first = 1;
                chk_busy   = 1;
            end
            if (out_valid) begin
                if (wait_first) begin
                    chk("first_valid_latency", 64'(cyc - acc_cyc), 64'(WIDTH + 1));
                    wait_first = 0;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_char actual=%0h required=none", out_char);
                end else begin
                    chk("char", 64'(out_char), 64'(exp_q[0]));
                    chk("last", 64'(out_last), 64'(last_q[0]));
                    if (out_ready) begin
                        field_beat = last_q[0] ? 0 : field_beat + 1;
                        void'(exp_q.pop_front());
                        void'(last_q.pop_front());
                    end
                end
            end
        end
    end

    // Called and returns at posedge+1; holds in_valid high, scrambling data
    // while the block is busy so only the intended word can be captured.
    task automatic send(logic [WIDTH-1:0] d, logic s);
        int n = 0;
        in_data   = d;
        in_signed = s;
        in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            in_data   = $urandom;
            in_signed = 1'($urandom % 2);
            n++;
            if (n > 5000) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=busy required=in_ready");
                return;
            end
        end
        in_data   = d;
        in_signed = s;
        push_exp(d, s);
        @(posedge clk);
        #1;
        in_data   = $urandom;
        in_signed = 1'($urandom % 2);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_char"},  64'(out_char),  64'h20);
        chk({tag, "_out_last"},  64'(out_last),  64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    logic [WIDTH-1:0] rd;
    int               n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed values, held back-to-back.
        ready_mode = 0;
        send(32'hFFFF_FFF4, 1'b1);
        send(32'd97, 1'b0);
        send(32'd0, 1'b0);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h8000_0000, 1'b1);
        send(32'h7FFF_FFFF, 1'b1);
        send(32'd0, 1'b1);
        in_valid = 1'b0;
        drain();

        // Random backpressure, then a long stall.
        ready_mode = 1;
        send(32'd120, 1'b0);
        in_valid = 1'b0;
        drain();
        ready_mode = 2;
        send(32'd4096, 1'b1);
        in_valid = 1'b0;
        idle(150);
        ready_mode = 0;
        drain();

        // Back-to-back small values.
        send(32'd5, 1'b0);
        send(32'd6, 1'b0);
        in_valid = 1'b0;
        drain();

        // Randomized words.
        for (int w = 0; w < 40; w++) begin
            ready_mode = int'($urandom % 2);
            case ($urandom % 4)
                0:       rd = $urandom;
                1:       rd = $urandom_range(0, 999);
                2:       rd = -$urandom_range(0, 999);
                default: rd = ($urandom % 2) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            endcase
            send(rd, 1'($urandom % 2));
            if ($urandom % 2) begin
                in_valid = 1'b0;
                idle(int'($urandom_range(0, 3)));
            end
        end
        in_valid   = 1'b0;
        ready_mode = 0;
        drain();

        // Abort at EMIT index 4, then a clean field.
        send(32'd12345, 1'b0);
        in_valid = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            n++;
            if ((field_beat == 4 && out_valid) || n > 2000) break;
        end
        chk("reached_emit_index4", 64'(field_beat), 64'd4);
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("abort");
        exp_q.delete();
        last_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'd7, 1'b0);
        in_valid = 1'b0;
        drain();
        idle(2);
        chk_idle_outputs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fmt_dec_ascii.md
Name: fmt_dec_ascii

Overview:
- Sequential decimal formatter: accepts one binary word per handshake and streams its `%d`-style ASCII rendering, one character per beat, MSB character first.
- Field is right-justified and space-padded to the fixed `%d` field width, with '-' for negative signed values.
- Sits upstream of the character sink (console/string buffer/UART). Produces byte-exact `$display`/`$sformatf("%d")` text in hardware.

Parameters:
- WIDTH, 32, bit width of in_data (legal 4..64).
- NDIG, 10, decimal digits of 2**WIDTH-1; the integrator sets it consistently with WIDTH (32->10, 16->5, 8->3).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block can accept a word
- in_data  in  WIDTH  value to format
- in_signed  in  1  1 = treat in_data as two's complement
- out_valid  out  1  out_char valid
- out_ready  in  1  sink accepts out_char
- out_char  out  8  ASCII character
- out_last  out  1  marks final character of the field
- busy  out  1  high in CONV or EMIT

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: state=IDLE; in_ready=1; out_valid=0; out_char=8'h20; out_last=0; busy=0.
  - rst_n low mid-conversion or mid-emit aborts immediately.
  - No partial field resumes after reset.
- Field length:
  - L = NDIG when the latched signed flag is 0.
  - L = NDIG+1 when it is 1, even for non-negative values.
- Input handshake:
  - A word is accepted when in_valid && in_ready in IDLE.
  - in_data and in_signed are latched on acceptance; in_ready drops the next cycle.
- IDLE -> CONV on accept:
  - Magnitude = -in_data if signed and MSB set, else in_data. Use a WIDTH+1-bit negate so -2**(WIDTH-1) is correct.
  - Neg flag is latched.
- CONV:
  - Double-dabble over exactly WIDTH cycles into a 4*NDIG BCD register.
  - Each cycle adds 3 to every nibble >=5, then shifts one magnitude bit in.
  - Transitions to EMIT after the WIDTH-th cycle.
- EMIT:
  - Character index i runs 0..L-1.
  - out_valid is high throughout; out_char/out_last are stable while out_valid && !out_ready.
  - i advances only on out_valid && out_ready.
- Character selection:
  - Let k be the index of the most significant nonzero digit (k = last digit if value is 0).
  - Positions before the sign slot emit ' ' (8'h20).
  - The sign slot, immediately before digit k, emits '-' if neg, else ' '. It exists only when signed.
  - Digits from k onward emit 8'h30+digit.
  - A value of zero prints a single '0'.
- out_last is high on character L-1. Its handshake returns to IDLE with in_ready=1 in the next cycle; there are no bubbles beyond that.
- Latency:
  - Accept at cycle 0; first out_valid at cycle WIDTH+1.
  - Minimum occupancy is WIDTH+L+1 cycles per word.
- in_valid during CONV/EMIT is ignored; the word is not captured until in_ready is high.
- out_ready held low indefinitely stalls EMIT with no loss.

Optional Feature:
- Macro: FMT_DEC_ZERO_PAD_EN.
- When defined, the field renders as `%0Nd`-style zero padding:
  - The sign slot (if signed) is always position 0: '-' or ' '.
  - All leading pad positions emit '0' instead of ' '.
  - Example: unsigned 97 -> "0000000097".
- When undefined, space padding as specified above. L and timing are identical in both builds.

Test Plan:
- WIDTH=32, in_signed=1, in_data=-12 (32'hFFFFFFF4), out_ready=1 -> 11 chars "        -12" (8 spaces, '-', '1', '2'), out_last on 11th beat, first out_valid 33 cycles after accept.
- in_signed=0, in_data=97 -> "        97" (10 chars); in_data=0 -> "         0"; in_data=32'hFFFFFFFF -> "4294967295".
- in_signed=1, in_data=32'h80000000 -> "-2147483648" (no pad); in_data=32'h7FFFFFFF -> " 2147483647".
- Backpressure: value 120 unsigned, out_ready toggled 1,0,0,1 pseudo-randomly -> exact "       120" with no drop or duplicate; out_char stable while stalled.
- Back-to-back: in_valid held high with 5 then 6 -> "         5" then "         6"; in_ready high exactly one cycle between fields; in_data changes while busy are ignored.
- Reset: assert rst_n low at EMIT index 4 -> out_valid=0 and in_ready=1 asynchronously; next word 7 yields a clean "         7". With FMT_DEC_ZERO_PAD_EN, signed -12 -> "-0000000012".
